adc_sample_capture: RTL
=======================

// Module: adc_sample_capture
// PURPOSE
//   Front-end controller for the 8-bit parallel ADC that feeds the digital
//   compensator/encoder. It issues periodic CONVST_BAR strobes and tracks the
//   ADC BUSY handshake. It reads the conversion result via CS_BAR/RD_BAR and
//   presents it as a registered sample with a one-cycle valid pulse. It
//   replaces the ad-hoc convst_bar generation in top.
// PARAMETERS
//   SAMPLE_DIV    500  clk cycles per sample period (5us at 100MHz); min 64
//   CONVST_LOW    4    cycles convst_bar is held low per conversion
//   RD_CYCLES     3    cycles cs_bar/rd_bar are held low; data latched on last
//   CONV_TIMEOUT  200  max cycles from convst release to busy falling
// PORTS
//   clk           in   1  system clock
//   rst           in   1  reset; synchronous, active-low
//   en            in   1  enable sampling; low forces IDLE, clears counter/errors
//   busy          in   1  ADC busy, active high, asynchronous to clk
//   adc_data      in   8  ADC parallel output, valid while rd_bar low
//   convst_bar    out  1  conversion start, active low
//   cs_bar        out  1  ADC chip select, active low
//   rd_bar        out  1  ADC read strobe, active low
//   sample        out  8  last captured (or filtered) sample
//   sample_valid  out  1  one-cycle pulse when sample updates
//   timeout_err   out  1  sticky: busy handshake timed out
//   overrun_err   out  1  sticky: period tick arrived while FSM not IDLE
// BEHAVIOUR
//   - Reset (rst=0 at clk edge):
//     - convst_bar=1, cs_bar=1, rd_bar=1, sample=0, sample_valid=0,
//       timeout_err=0, overrun_err=0.
//     - FSM=IDLE, period counter=0, busy synchronizer=0.
//   - busy passes a 2-flop synchronizer (busy_s). All decisions use busy_s.
//   - Period counter: while en=1, it counts 0..SAMPLE_DIV-1 and wraps. tick=(cnt==0).
//   - FSM:
//     - IDLE: on tick, go to CONV.
//       - tick while not IDLE: set overrun_err and drop the tick (no queuing).
//     - CONV: convst_bar=0 for exactly CONVST_LOW cycles, then go to WAIT.
//     - WAIT: timer counts from 0.
//       - Record seen_hi when busy_s=1.
//       - seen_hi && busy_s==0: go to READ.
//       - timer==CONV_TIMEOUT-1 without that condition: set timeout_err,
//         return to IDLE with no read and no valid.
//     - READ: cs_bar=rd_bar=0 for RD_CYCLES cycles. On the last cycle,
//       latch adc_data into raw, then go to DONE.
//     - DONE: sample<=result, sample_valid=1 for this single cycle, go to IDLE.
//   - Latency: tick to sample_valid = CONVST_LOW + (busy wait) + RD_CYCLES + 1
//     cycles, plus 2 cycles of synchronizer delay on busy.
//   - cs_bar and rd_bar always toggle together. convst_bar is never low while
//     rd_bar is low.
//   - en deasserted mid-conversion:
//     - next edge: IDLE, all strobes high, counter=0, errors cleared.
//     - sample holds its value; no valid pulse.
//   - rst mid-conversion behaves identically but also zeroes sample and the filter.
//   - busy already high when entering WAIT counts as seen_hi.
//   - Errors are sticky until en=0 or reset.
// CONFIGURATION
//   AVG_FILTER_EN defined:
//     - result = (raw + last 3 raws + 2) >> 2. Accumulate in 10 bits, round,
//       then truncate to 8 bits.
//     - History resets to 0. The first 3 outputs are biased low by design.
//   AVG_FILTER_EN undefined: result = raw; no history registers.
// TESTING
//   1 rst=0 for 5 cycles, en=1, ADC model: busy high 20 cycles after convst
//     rising, data=8'hC0 -> first convst_bar low at cnt 0 for 4 cycles;
//     sample=8'hC0 with a 1-cycle valid; next convst exactly 500 cycles later.
//   2 ADC model never raises busy -> timeout_err=1 at CONV_TIMEOUT cycles;
//     no rd_bar activity; sample_valid stays 0; next tick retries.
//   3 busy held high 600 cycles (SAMPLE_DIV=500, CONV_TIMEOUT=700) ->
//     overrun_err=1 at the second tick; read completes once; one valid pulse.
//   4 en=0 during READ -> rd_bar/cs_bar high next cycle; no valid; errors
//     clear; sample holds previous value.
//   5 AVG_FILTER_EN, data sequence 200,200,200,200 -> outputs 50,100,150,200;
//     then 210 -> 203 ((210+600+2)>>2).
//   6 busy toggling asynchronously near clk edges -> no glitch on strobes;
//     convst_bar/rd_bar never low simultaneously (assertion).

Source files
------------

// File: rtl/adc_sample_capture.sv
// Periodic CONVST/BUSY/RD front end for an 8-bit parallel ADC.
// Define AVG_FILTER_EN to average each sample with the three previous raw reads.
`timescale 1ns/1ps
module adc_sample_capture #(
  parameter int SAMPLE_DIV   = 500,
  parameter int CONVST_LOW   = 4,
  parameter int RD_CYCLES    = 3,
  parameter int CONV_TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       busy,
  input  logic [7:0] adc_data,
  output logic       convst_bar,
  output logic       cs_bar,
  output logic       rd_bar,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       timeout_err,
  output logic       overrun_err,
  output logic [2:0] dbg_state
);
  typedef enum logic [2:0] {IDLE, CONV, WAIT, READ, DONE} state_t;

  localparam int CNT_W   = $clog2(SAMPLE_DIV);
  localparam int TMR_MAX = (CONV_TIMEOUT > CONVST_LOW) ?
                           ((CONV_TIMEOUT > RD_CYCLES) ? CONV_TIMEOUT : RD_CYCLES) :
                           ((CONVST_LOW > RD_CYCLES) ? CONVST_LOW : RD_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic             seen_hi, seen_hi_n;
  logic             busy_m, busy_s;
  logic             tick;
  logic             latch_raw;
  logic             to_fire;
  logic [7:0]       raw;
  logic [7:0]       result;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst || !en)                         cnt <= '0;
    else if (cnt == CNT_W'(SAMPLE_DIV - 1)) cnt <= '0;
    else                                     cnt <= cnt + CNT_W'(1);
  end

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_m <= 1'b0;
      busy_s <= 1'b0;
    end else begin
      busy_m <= busy;
      busy_s <= busy_m;
    end
  end

  always_comb begin
    state_n   = state;
    tmr_n     = tmr;
    seen_hi_n = seen_hi;
    latch_raw = 1'b0;
    to_fire   = 1'b0;
    case (state)
      IDLE: if (tick) begin
        state_n   = CONV;
        tmr_n     = '0;
        seen_hi_n = 1'b0;
      end
      // busy seen during the strobe still counts once WAIT is entered
      CONV: begin
        seen_hi_n = seen_hi | busy_s;
        if (tmr == TMR_W'(CONVST_LOW - 1)) begin
          state_n = WAIT;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr + TMR_W'(1);
        end
      end
      WAIT: begin
        seen_hi_n = seen_hi | busy_s;
        if (seen_hi && !busy_s) begin
          state_n = READ;
          tmr_n   = '0;
        end else if (tmr == TMR_W'(CONV_TIMEOUT - 1)) begin
          state_n = IDLE;
          to_fire = 1'b1;
        end else begin
          tmr_n = tmr + TMR_W'(1);
        end
      end
      READ: begin
        if (tmr == TMR_W'(RD_CYCLES - 1)) begin
          state_n   = DONE;
          latch_raw = 1'b1;
        end else begin
          tmr_n = tmr + TMR_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (!en) begin
      state_n   = IDLE;
      latch_raw = 1'b0;
      to_fire   = 1'b0;
    end
  end

  // Strobes are registered from the next state so they never glitch.
  // sample_valid: one-cycle pulse, no backpressure; sample holds until the next pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      tmr          <= '0;
      seen_hi      <= 1'b0;
      convst_bar   <= 1'b1;
      cs_bar       <= 1'b1;
      rd_bar       <= 1'b1;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      state        <= state_n;
      tmr          <= tmr_n;
      seen_hi      <= seen_hi_n;
      convst_bar   <= (state_n != CONV);
      cs_bar       <= (state_n != READ);
      rd_bar       <= (state_n != READ);
      sample_valid <= en && (state == DONE);
      if (!en) begin
        timeout_err <= 1'b0;
        overrun_err <= 1'b0;
      end else begin
        if (to_fire)                  timeout_err <= 1'b1;
        if (tick && (state != IDLE)) overrun_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      raw    <= '0;
      sample <= '0;
    end else begin
      if (latch_raw)              raw    <= adc_data;
      if (en && (state == DONE)) sample <= result;
    end
  end

`ifdef AVG_FILTER_EN
  logic [7:0] h1, h2, h3;
  logic [9:0] acc;

  // Rounded mean of four reads; history starts at zero so early outputs read low.
  assign acc    = 10'(raw) + 10'(h1) + 10'(h2) + 10'(h3) + 10'd2;
  assign result = acc[9:2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      h1 <= '0;
      h2 <= '0;
      h3 <= '0;
    end else if (en && (state == DONE)) begin
      h1 <= raw;
      h2 <= h1;
      h3 <= h2;
    end
  end
`else
  assign result = raw;
`endif

endmodule
